lsu_bridge: RTL and testbench
=============================

LSU_BRIDGE -- requirements
Module: lsu_bridge

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, SHALL set the number of REQ cycles without bus_ack before a bus error is flagged (range 1..65535).
REQ-002 clk  in  1  single clock; all state SHALL change on the rising edge.
REQ-003 reset  in  1  SHALL be an asynchronous, active-low reset.
REQ-004 MemReq  in  1  core requests a data access this instruction (MemWrite or MemtoReg).
REQ-005 MemWrite  in  1  1 = store, 0 = load.
REQ-006 ByteEn  in  1  1 = byte access; ignored unless the macro is defined.
REQ-007 Addr  in  32  byte address (ALUResult).
REQ-008 WriteData  in  32  store data.
REQ-009 ReadData  out  32  registered load data to the datapath.
REQ-010 Stall  out  1  holds PC and register-file writes while high.
REQ-011 BusErr  out  1  one-cycle error pulse.
REQ-012 bus_req/bus_we  out  1/1, bus_addr/bus_wdata  out  32/32, bus_be  out  4, bus_ack  in  1, bus_rdata  in  32  external memory handshake.

Function
REQ-013 FSM states: IDLE, REQ, DONE.
REQ-014 In IDLE with MemReq=1 and a legal address, the FSM SHALL latch Addr, WriteData, MemWrite and ByteEn, then enter REQ on the next edge.
REQ-015 Stall SHALL be combinational: MemReq in IDLE, 1 in REQ, 0 in DONE.
REQ-016 bus_req SHALL be 1 exactly while in REQ, driven from latched values that stay stable until bus_ack is seen.
REQ-017 bus_ack=1 in REQ SHALL capture the formatted bus_rdata into ReadData (loads only), drop bus_req next cycle, and enter DONE.
REQ-018 Latency: ack on the first REQ cycle SHALL give Stall high for 2 cycles, with DONE on the 3rd; each wait state adds 1.
REQ-019 DONE SHALL last exactly one cycle and go to IDLE unconditionally; a MemReq seen in DONE SHALL NOT start a new access.
REQ-020 A 16-bit wait counter SHALL clear on entry to REQ; reaching TIMEOUT_CYC without ack SHALL go to DONE, set ReadData=32'h0, and pulse BusErr.
REQ-021 If bus_ack arrives in the same cycle the counter reaches TIMEOUT_CYC, ack SHALL win and BusErr SHALL stay 0.
REQ-022 A word access with Addr[1:0]!=0 SHALL issue no bus transaction; it SHALL go IDLE->DONE, pulse BusErr in DONE, and leave ReadData unchanged.
REQ-023 Word access SHALL use bus_be=4'hF, bus_addr={Addr[31:2],2'b00}, and pass data through unchanged.
REQ-024 Stores SHALL leave ReadData unchanged.

Reset
REQ-025 Asserting reset at any time, including mid-REQ, SHALL immediately force IDLE, bus_req=0, bus_we=0, bus_be=0, ReadData=0, BusErr=0, Stall=0, counter=0.
REQ-026 An interrupted transaction SHALL NOT be retried after reset release.

Configuration
REQ-027 Macro LSU_BYTE_ACCESS_EN defined: ByteEn=1 SHALL set bus_be to the one-hot lane for Addr[1:0], replicate WriteData[7:0] on all four lanes, and return the selected byte zero-extended; byte accesses are never misaligned.
REQ-028 Macro undefined: ByteEn SHALL be ignored and every access treated as a word access.

Structure
REQ-029 Package lsu_pkg SHALL hold the state enum, DEFAULT_TIMEOUT (255), and the error read value (32'h0).
REQ-030 Byte-lane steering (bus_be, wdata replication, rdata select/extend) SHALL live in sub-module lsu_byte_lane, instantiated in both configurations.

Verification
REQ-031 The bench SHALL cover each of the following directed scenarios:
- Load Addr=0x100 with ack on the first REQ cycle and bus_rdata=0x12345678 -> Stall high 2 cycles, ReadData=0x12345678 in DONE, BusErr=0.
- Store Addr=0x204, WriteData=0xCAFEF00D, ack after 3 wait states -> bus_we=1, bus_be=F, bus_wdata stable for 4 REQ cycles, Stall high 5 cycles.
- Load with TIMEOUT_CYC=4 and no ack -> BusErr pulse in DONE, ReadData=0; same run with ack on cycle 4 -> BusErr=0, data captured.
- Word load at Addr=0x102 -> bus_req never asserted, BusErr pulse one cycle later.
- Macro defined, byte load at Addr=0x103 with bus_rdata=0xAB000000 -> bus_be=4'b1000, ReadData=0x000000AB.
- Byte store of 0x5A at Addr=0x101 -> bus_be=4'b0010, bus_wdata=0x5A5A5A5A.
- reset low during the 2nd REQ cycle -> bus_req=0 immediately, IDLE after release, no retry.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store bridge: FSM encodings, default timeout
// and the value returned on a bus error.
package lsu_pkg;

    typedef logic [1:0] lsu_state_t;

    localparam lsu_state_t ST_IDLE = 2'd0;
    localparam lsu_state_t ST_REQ  = 2'd1;
    localparam lsu_state_t ST_DONE = 2'd2;

    localparam int unsigned DEFAULT_TIMEOUT = 255;
    localparam logic [31:0] ERR_RDATA       = 32'h0;

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane steering between the core and a 32-bit bus: lane enables, store
// data replication and load byte selection with zero extension.
module lsu_byte_lane (
    input  logic        byte_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    always_comb begin
        be_o    = '1;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        if (byte_i) begin
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
            case (addr_lo_i)
                2'd0:    rdata_o = {24'h0, rdata_i[7:0]};
                2'd1:    rdata_o = {24'h0, rdata_i[15:8]};
                2'd2:    rdata_o = {24'h0, rdata_i[23:16]};
                default: rdata_o = {24'h0, rdata_i[31:24]};
            endcase
        end
    end

endmodule

// File: rtl/lsu_bridge.sv
// Load/store bridge from the single-cycle core datapath to a req/ack memory bus.
// Byte accesses are honoured only when LSU_BYTE_ACCESS_EN is defined.
module lsu_bridge
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic        ByteEn,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        BusErr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [15:0] TMO = 16'(TIMEOUT_CYC);

    lsu_state_t  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        byte_q, byte_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        byte_eff;
    logic        misaligned;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;

`ifdef LSU_BYTE_ACCESS_EN
    assign byte_eff = ByteEn;
`else
    logic unused_byteen;
    assign unused_byteen = ByteEn;
    assign byte_eff      = 1'b0;
`endif

    assign misaligned = !byte_eff && (Addr[1:0] != 2'b00);

    lsu_byte_lane u_lane (
        .byte_i    (byte_q),
        .addr_lo_i (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rdata_i   (bus_rdata),
        .be_o      (lane_be),
        .wdata_o   (lane_wdata),
        .rdata_o   (lane_rdata)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        byte_d  = byte_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (MemReq) begin
                    addr_d  = Addr;
                    wdata_d = WriteData;
                    we_d    = MemWrite;
                    byte_d  = byte_eff;
                    // Misaligned word accesses skip the bus and report in DONE.
                    if (misaligned) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                        cnt_d   = '0;
                    end
                end
            end
            ST_REQ: begin
                if (bus_ack) begin
                    if (!we_q) rdata_d = lane_rdata;
                    state_d = ST_DONE;
                end else if (cnt_q + 16'd1 == TMO) begin
                    rdata_d = ERR_RDATA;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            byte_q  <= byte_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        case (state_q)
            ST_IDLE: Stall = MemReq;
            ST_REQ:  Stall = 1'b1;
            default: Stall = 1'b0;
        endcase
    end

    assign bus_req   = (state_q == ST_REQ);
    assign bus_we    = bus_req && we_q;
    assign bus_be    = bus_req ? lane_be : '0;
    assign bus_addr  = {addr_q[31:2], 2'b00};
    assign bus_wdata = lane_wdata;
    assign ReadData  = rdata_q;
    assign BusErr    = err_q;

endmodule

// File: tb/tb_lsu_bridge.sv
// Directed self-checking bench for lsu_bridge; byte-lane scenarios follow
// LSU_BYTE_ACCESS_EN, otherwise ByteEn must be ignored.
module tb_lsu_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReq, MemWrite, ByteEn;
    logic [31:0] Addr, WriteData, ReadData;
    logic        Stall, BusErr;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int checks = 0;
    int errors = 0;
    int stall_cnt;

    always #5 clk = ~clk;

    lsu_bridge #(.TIMEOUT_CYC(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemReq    (MemReq),
        .MemWrite  (MemWrite),
        .ByteEn    (ByteEn),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .BusErr    (BusErr),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_be    (bus_be),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; MemReq = 1'b0; MemWrite = 1'b0; ByteEn = 1'b0;
        Addr = '0; WriteData = '0; bus_ack = 1'b0; bus_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ReadData", ReadData, 32'h0);
        chk("rst_Stall", {31'h0, Stall}, 32'h0);
        chk("rst_BusErr", {31'h0, BusErr}, 32'h0);
        chk("rst_bus_req", {31'h0, bus_req}, 32'h0);
        chk("rst_bus_we", {31'h0, bus_we}, 32'h0);
        chk("rst_bus_be", {28'h0, bus_be}, 32'h0);
        cyc();
        reset = 1'b1;

        // Word load, ack on first REQ cycle
        MemReq = 1'b1; MemWrite = 1'b0; Addr = 32'h100;
        @(negedge clk);
        chk("ld_idle_stall", {31'h0, Stall}, 32'h1);
        chk("ld_idle_req", {31'h0, bus_req}, 32'h0);
        cyc();
        MemReq = 1'b0; Addr = '0; bus_ack = 1'b1; bus_rdata = 32'h12345678;
        @(negedge clk);
        chk("ld_req", {31'h0, bus_req}, 32'h1);
        chk("ld_addr", bus_addr, 32'h100);
        chk("ld_be", {28'h0, bus_be}, 32'hF);
        chk("ld_we", {31'h0, bus_we}, 32'h0);
        chk("ld_req_stall", {31'h0, Stall}, 32'h1);
        cyc();
        bus_ack = 1'b0; bus_rdata = '0;
        @(negedge clk);
        chk("ld_done_stall", {31'h0, Stall}, 32'h0);
        chk("ld_rdata", ReadData, 32'h12345678);
        chk("ld_buserr", {31'h0, BusErr}, 32'h0);
        chk("ld_done_req", {31'h0, bus_req}, 32'h0);
        cyc();

        // Word store, three wait states (ack on 4th REQ cycle)
        MemReq = 1'b1; MemWrite = 1'b1; Addr = 32'h204; WriteData = 32'hCAFEF00D;
        stall_cnt = 0;
        @(negedge clk);
        if (Stall) stall_cnt++;
        cyc();
        MemReq = 1'b0; Addr = '0; WriteData = '0;
        for (int i = 0; i < 4; i++) begin
            bus_ack = (i == 3);
            @(negedge clk);
            if (Stall) stall_cnt++;
            chk("st_req", {31'h0, bus_req}, 32'h1);
            chk("st_we", {31'h0, bus_we}, 32'h1);
            chk("st_be", {28'h0, bus_be}, 32'hF);
            chk("st_wdata", bus_wdata, 32'hCAFEF00D);
            chk("st_addr", bus_addr, 32'h204);
            cyc();
        end
        bus_ack = 1'b0; MemWrite = 1'b0;
        @(negedge clk);
        if (Stall) stall_cnt++;
        chk("st_stall_cycles", stall_cnt, 32'd5);
        chk("st_rdata_kept", ReadData, 32'h12345678);
        chk("st_done_req", {31'h0, bus_req}, 32'h0);
        chk("st_buserr", {31'h0, BusErr}, 32'h0);
        cyc();

        // Load timeout with no ack
        MemReq = 1'b1; Addr = 32'h300;
        cyc();
        MemReq = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("to_req", {31'h0, bus_req}, 32'h1);
            cyc();
        end
        @(negedge clk);
        chk("to_buserr", {31'h0, BusErr}, 32'h1);
        chk("to_rdata", ReadData, 32'h0);
        chk("to_stall", {31'h0, Stall}, 32'h0);
        chk("to_done_req", {31'h0, bus_req}, 32'h0);
        cyc();
        @(negedge clk);
        chk("to_pulse_end", {31'h0, BusErr}, 32'h0);
        cyc();

        // Ack on the same cycle the timeout is reached
        MemReq = 1'b1; Addr = 32'h304;
        cyc();
        MemReq = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_ack = (i == 3); bus_rdata = 32'hDEADBEEF;
            @(negedge clk);
            chk("tack_req", {31'h0, bus_req}, 32'h1);
            cyc();
        end
        bus_ack = 1'b0; bus_rdata = '0;
        @(negedge clk);
        chk("tack_buserr", {31'h0, BusErr}, 32'h0);
        chk("tack_rdata", ReadData, 32'hDEADBEEF);
        cyc();

        // Misaligned word load; MemReq held in DONE must not start an access
        MemReq = 1'b1; Addr = 32'h102;
        @(negedge clk);
        chk("mis_idle_stall", {31'h0, Stall}, 32'h1);
        chk("mis_idle_req", {31'h0, bus_req}, 32'h0);
        cyc();
        Addr = 32'h108;
        @(negedge clk);
        chk("mis_buserr", {31'h0, BusErr}, 32'h1);
        chk("mis_req", {31'h0, bus_req}, 32'h0);
        chk("mis_rdata_kept", ReadData, 32'hDEADBEEF);
        chk("mis_done_stall", {31'h0, Stall}, 32'h0);
        cyc();
        MemReq = 1'b0;
        @(negedge clk);
        chk("done_no_start", {31'h0, bus_req}, 32'h0);
        chk("mis_pulse_end", {31'h0, BusErr}, 32'h0);
        cyc();

`ifdef LSU_BYTE_ACCESS_EN
        // Byte load from lane 3
        MemReq = 1'b1; ByteEn = 1'b1; Addr = 32'h103;
        cyc();
        MemReq = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hAB000000;
        @(negedge clk);
        chk("bld_req", {31'h0, bus_req}, 32'h1);
        chk("bld_be", {28'h0, bus_be}, 32'h8);
        chk("bld_addr", bus_addr, 32'h100);
        cyc();
        bus_ack = 1'b0; bus_rdata = '0;
        @(negedge clk);
        chk("bld_rdata", ReadData, 32'h000000AB);
        chk("bld_buserr", {31'h0, BusErr}, 32'h0);
        cyc();

        // Byte store to lane 1
        MemReq = 1'b1; MemWrite = 1'b1; ByteEn = 1'b1; Addr = 32'h101; WriteData = 32'h1234565A;
        cyc();
        MemReq = 1'b0; bus_ack = 1'b1;
        @(negedge clk);
        chk("bst_be", {28'h0, bus_be}, 32'h2);
        chk("bst_wdata", bus_wdata, 32'h5A5A5A5A);
        chk("bst_we", {31'h0, bus_we}, 32'h1);
        cyc();
        bus_ack = 1'b0; MemWrite = 1'b0; ByteEn = 1'b0;
        @(negedge clk);
        chk("bst_rdata_kept", ReadData, 32'h000000AB);
        cyc();
`else
        // ByteEn ignored: byte load at 0x103 is a misaligned word access
        MemReq = 1'b1; ByteEn = 1'b1; Addr = 32'h103;
        cyc();
        MemReq = 1'b0; ByteEn = 1'b0;
        @(negedge clk);
        chk("nbyte_req", {31'h0, bus_req}, 32'h0);
        chk("nbyte_buserr", {31'h0, BusErr}, 32'h1);
        chk("nbyte_rdata_kept", ReadData, 32'hDEADBEEF);
        cyc();
`endif

        // Reset asserted during the 2nd REQ cycle
        MemReq = 1'b1; MemWrite = 1'b0; Addr = 32'h400;
        cyc();
        MemReq = 1'b0;
        @(negedge clk);
        chk("rreq_req1", {31'h0, bus_req}, 32'h1);
        cyc();
        reset = 1'b0;
        #1;
        chk("rreq_bus_req", {31'h0, bus_req}, 32'h0);
        chk("rreq_stall", {31'h0, Stall}, 32'h0);
        chk("rreq_rdata", ReadData, 32'h0);
        chk("rreq_be", {28'h0, bus_be}, 32'h0);
        chk("rreq_buserr", {31'h0, BusErr}, 32'h0);
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rreq_no_retry", {31'h0, bus_req}, 32'h0);
            chk("rreq_idle_stall", {31'h0, Stall}, 32'h0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
